// File: rtl/midi_pkg.sv
// Shared MIDI definitions used by both the transmitter and the keyboard receiver.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam int         MIDI_BAUD     = 31250;

  typedef struct packed {
    logic       on;
    logic [3:0] channel;
    logic [6:0] key;
    logic [6:0] velocity;
  } note_cmd_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STATUS,
    TX_KEY,
    TX_VEL
  } tx_state_t;

  function automatic logic [7:0] status_byte(input note_cmd_t cmd);
    return {(cmd.on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), cmd.channel};
  endfunction

endpackage

// File: rtl/midi_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit, each BIT_CYCLES long.
module midi_tx_byte #(
  parameter int BIT_CYCLES = 2080
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       serial,
  output logic       byte_done
);

  localparam int             CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_CYC = CW'(BIT_CYCLES - 1);

  logic          active;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cyc;
  logic [7:0]    shift;

  // Combinational so the next byte can be loaded on the very edge the stop bit ends.
  assign byte_done = active && (cyc == LAST_CYC) && (bit_cnt == 4'd9);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      bit_cnt <= 4'd0;
      cyc     <= '0;
      shift   <= 8'h00;
      serial  <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      bit_cnt <= 4'd0;
      cyc     <= '0;
      shift   <= data;
      serial  <= 1'b0;
    end else if (active) begin
      if (cyc == LAST_CYC) begin
        cyc <= '0;
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          bit_cnt <= 4'd0;
          serial  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          // Moving to bit bit_cnt+1: data bits 1..8 carry shift[bit_cnt], bit 9 is the stop.
          serial  <= (bit_cnt == 4'd8) ? 1'b1 : shift[bit_cnt[2:0]];
        end
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI transmitter: message FSM and running-status tracking on top of the byte serialiser.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ         = 65_000_000,
  parameter int BAUD           = MIDI_BAUD,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_on,
  input  logic [3:0] cmd_channel,
  input  logic [6:0] cmd_key,
  input  logic [6:0] cmd_velocity,
  output logic       serial,
  output logic       busy,
  output logic       msg_done
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD;

  generate
    if ((CLK_HZ % BAUD) != 0) begin : g_baud_check
      $error("midi_tx: CLK_HZ must be an exact multiple of BAUD");
    end
  endgenerate

  tx_state_t  state, next_state;
  note_cmd_t  new_cmd, cmd_q;
  logic [7:0] new_status, last_status;
  logic       last_valid, skip_status, accept;
  logic       load, byte_done;
  logic [7:0] load_data;

  assign new_cmd     = {cmd_on, cmd_channel, cmd_key, cmd_velocity};
  assign new_status  = status_byte(new_cmd);
  assign skip_status = (RUNNING_STATUS != 0) && last_valid && (last_status == new_status);
  assign cmd_ready   = (state == TX_IDLE);
  assign busy        = ~cmd_ready;
  assign accept      = cmd_valid && cmd_ready;

  // Each byte is handed over on the edge the previous one finishes, so bytes run gap-free.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_data  = 8'h00;
    case (state)
      TX_IDLE: begin
        if (cmd_valid) begin
          load       = 1'b1;
          load_data  = skip_status ? {1'b0, cmd_key} : new_status;
          next_state = skip_status ? TX_KEY : TX_STATUS;
        end
      end
      TX_STATUS: begin
        if (byte_done) begin
          load       = 1'b1;
          load_data  = {1'b0, cmd_q.key};
          next_state = TX_KEY;
        end
      end
      TX_KEY: begin
        if (byte_done) begin
          load       = 1'b1;
          load_data  = {1'b0, cmd_q.velocity};
          next_state = TX_VEL;
        end
      end
      TX_VEL: begin
        if (byte_done) next_state = TX_IDLE;
      end
      default: next_state = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= TX_IDLE;
      cmd_q       <= '0;
      last_status <= 8'h00;
      last_valid  <= 1'b0;
      msg_done    <= 1'b0;
    end else begin
      state    <= next_state;
      msg_done <= (state == TX_VEL) && byte_done;
      if (accept) begin
        cmd_q <= new_cmd;
        if (!skip_status) begin
          last_status <= new_status;
          last_valid  <= 1'b1;
        end
      end
    end
  end

  midi_tx_byte #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_byte (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .data     (load_data),
    .serial   (serial),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: directed and random note commands against a byte-level MIDI model.
module tb_midi_tx;

  localparam int B    = 16;
  localparam int HALF = B / 2;

  logic       clock;
  logic       reset;
  logic       valid0, valid1;
  logic       cmd_on;
  logic [3:0] cmd_channel;
  logic [6:0] cmd_key, cmd_velocity;
  logic       ready0, ready1, serial0, serial1, busy0, busy1, done0, done1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  bit         m_valid[2];
  logic [7:0] m_last[2];
  int         rs_for[2] = '{1, 0};

  midi_tx #(.CLK_HZ(500_000), .BAUD(31250), .RUNNING_STATUS(1)) u_tx_rs (
    .clock(clock), .reset(reset), .cmd_valid(valid0), .cmd_ready(ready0),
    .cmd_on(cmd_on), .cmd_channel(cmd_channel), .cmd_key(cmd_key),
    .cmd_velocity(cmd_velocity), .serial(serial0), .busy(busy0), .msg_done(done0)
  );

  midi_tx #(.CLK_HZ(500_000), .BAUD(31250), .RUNNING_STATUS(0)) u_tx_plain (
    .clock(clock), .reset(reset), .cmd_valid(valid1), .cmd_ready(ready1),
    .cmd_on(cmd_on), .cmd_channel(cmd_channel), .cmd_key(cmd_key),
    .cmd_velocity(cmd_velocity), .serial(serial1), .busy(busy1), .msg_done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected wire bytes for one command, from the MIDI channel-message rules.
  task automatic model_build(input int which, input bit on, input int ch, input int key, input int vel);
    logic [7:0] st;
    exp_q.delete();
    st = {(on ? 4'h9 : 4'h8), 4'(ch)};
    if (!(rs_for[which] != 0 && m_valid[which] && m_last[which] == st)) begin
      exp_q.push_back(st);
      m_valid[which] = 1'b1;
      m_last[which]  = st;
    end
    exp_q.push_back({1'b0, 7'(key)});
    exp_q.push_back({1'b0, 7'(vel)});
  endtask

  task automatic set_fields(input bit on, input int ch, input int key, input int vel);
    cmd_on       = on;
    cmd_channel  = 4'(ch);
    cmd_key      = 7'(key);
    cmd_velocity = 7'(vel);
  endtask

  // Called just after the accept edge; ends at the falling edge of the msg_done cycle.
  task automatic checkOutput(input int which, input string tag);
    int         total;
    logic       s, d, r;
    logic [7:0] got;
    bit         early_done, ready_seen;
    total      = exp_q.size() * 10 * B;
    got        = 8'h00;
    early_done = 1'b0;
    ready_seen = 1'b0;
    for (int c = 0; c < total; c++) begin
      @(negedge clock);
      s = (which == 0) ? serial0 : serial1;
      d = (which == 0) ? done0 : done1;
      r = (which == 0) ? ready0 : ready1;
      if (d) early_done = 1'b1;
      if (r) ready_seen = 1'b1;
      if (c == 0) check_eq({tag, " start_on_accept_edge"}, s, 1'b0);
      if ((c % B) == HALF) begin
        int bi, pos;
        bi  = (c / B) / 10;
        pos = (c / B) % 10;
        if (pos == 0) check_eq($sformatf("%s byte%0d start", tag, bi), s, 1'b0);
        else if (pos == 9) begin
          check_eq($sformatf("%s byte%0d stop", tag, bi), s, 1'b1);
          check_eq($sformatf("%s byte%0d data", tag, bi), got, exp_q[bi]);
        end else got[pos-1] = s;
      end
    end
    @(negedge clock);
    check_eq({tag, " msg_done"}, (which == 0) ? done0 : done1, 1'b1);
    check_eq({tag, " ready_at_done"}, (which == 0) ? ready0 : ready1, 1'b1);
    check_eq({tag, " idle_line"}, (which == 0) ? serial0 : serial1, 1'b1);
    check_eq({tag, " done_not_early"}, early_done, 1'b0);
    check_eq({tag, " not_ready_while_busy"}, ready_seen, 1'b0);
  endtask

  task automatic applyStimulus(input int which, input bit on, input int ch, input int key,
                               input int vel, input string tag);
    model_build(which, on, ch, key, vel);
    @(negedge clock);
    set_fields(on, ch, key, vel);
    if (which == 0) valid0 = 1'b1; else valid1 = 1'b1;
    check_eq({tag, " ready_before"}, (which == 0) ? ready0 : ready1, 1'b1);
    @(posedge clock);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    checkOutput(which, tag);
  endtask

  initial begin
    reset = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    set_fields(1'b0, 0, 0, 0);
    m_valid = '{1'b0, 1'b0};
    m_last  = '{8'h00, 8'h00};
    repeat (3) @(negedge clock);
    check_eq("reset serial", serial0, 1'b1);
    check_eq("reset ready", ready0, 1'b1);
    check_eq("reset busy", busy0, 1'b0);
    check_eq("reset msg_done", done0, 1'b0);
    reset = 1'b1;

    applyStimulus(0, 1'b1, 0, 60, 100, "on_ch0_full");
    applyStimulus(0, 1'b1, 0, 64, 80, "on_ch0_running");
    applyStimulus(0, 1'b0, 0, 60, $urandom_range(0, 127), "off_ch0_full");
    applyStimulus(0, 1'b0, 0, $urandom_range(0, 127), $urandom_range(0, 127), "off_ch0_running");
    applyStimulus(0, 1'b1, 3, $urandom_range(0, 127), $urandom_range(0, 127), "on_ch3");

    // Back-to-back: valid stays high, second command waits for the msg_done cycle.
    begin
      int k1, v1, k2, v2;
      k1 = $urandom_range(0, 127); v1 = $urandom_range(0, 127);
      k2 = $urandom_range(0, 127); v2 = $urandom_range(0, 127);
      model_build(0, 1'b1, 3, k1, v1);
      @(negedge clock);
      set_fields(1'b1, 3, k1, v1);
      valid0 = 1'b1;
      @(posedge clock);
      #1;
      set_fields(1'b1, 5, k2, v2);
      checkOutput(0, "b2b_first");
      check_eq("b2b busy_in_done_cycle", busy0, 1'b0);
      model_build(0, 1'b1, 5, k2, v2);
      @(posedge clock);
      #1;
      valid0 = 1'b0;
      checkOutput(0, "b2b_second");
    end

    // Reset during the key byte of a running-status message.
    applyStimulus(0, 1'b1, 0, 60, 100, "pre_reset_full");
    @(negedge clock);
    set_fields(1'b1, 0, 60, 100);
    valid0 = 1'b1;
    @(posedge clock);
    #1;
    valid0 = 1'b0;
    repeat (HALF) @(negedge clock);
    check_eq("abort key_start_bit", serial0, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("abort serial_async", serial0, 1'b1);
    check_eq("abort ready", ready0, 1'b1);
    check_eq("abort busy", busy0, 1'b0);
    m_valid = '{1'b0, 1'b0};
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, 1'b1, 0, 60, 100, "after_reset_full");

    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 127),
                    $urandom_range(0, 127), $sformatf("rand%0d", i));

    applyStimulus(1, 1'b1, 0, 60, 100, "plain_first");
    applyStimulus(1, 1'b1, 0, 60, 100, "plain_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
